// File: rtl/ca_search_sequencer.sv
// ca_search_sequencer
// -------------------
// Runs a serial code-phase search for one PRN. For each bin it programs a
// code-shift target into the C/A upsampler seek port and waits for the seek
// to finish. It then clears the correlator, dwells for DWELL input samples,
// dumps the correlator and keeps the strongest bin seen so far.
//
// Optional feature macro: CA_SEARCH_THRESH_EN
//   defined   - a bin whose power reaches `threshold` ends the search early
//               and raises `found`.
//   undefined - `threshold` is ignored, `found` is tied to 0 and every bin
//               is visited.
//
// Ports
//   clk, reset_n        system clock, synchronous active-low reset
//   start, abort        one-cycle search request (IDLE only) / cancel
//   prn_in, start_shift, num_bins
//                       search setup, latched on start (num_bins 0 -> 1)
//   threshold           early-stop power level (feature build only)
//   sample_valid        upsampler sample strobe, counted during DWELL
//   seeking             upsampler seek-in-progress flag
//   corr_power(_valid)  correlator result, accepted only in WAIT_RES
//   prn, seek_en, seek_target
//                       upsampler control
//   corr_clear, corr_dump
//                       one-cycle correlator controls
//   busy, done, found   status (done is a one-cycle pulse)
//   best_shift, best_power
//                       peak bin result, held until the next start
module ca_search_sequencer #(
    parameter int CODE_LEN = 16800,
    parameter int STEP     = 8,
    parameter int DWELL    = 16800
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  prn_in,
    input  logic [14:0] start_shift,
    input  logic [11:0] num_bins,
    input  logic [31:0] threshold,
    input  logic        sample_valid,
    input  logic        seeking,
    input  logic [31:0] corr_power,
    input  logic        corr_power_valid,
    output logic [4:0]  prn,
    output logic        seek_en,
    output logic [14:0] seek_target,
    output logic        corr_clear,
    output logic        corr_dump,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [14:0] best_shift,
    output logic [31:0] best_power
);

    localparam int              DCW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [15:0]     STEP16     = 16'(STEP);
    localparam logic [15:0]     CODE16     = 16'(CODE_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_SETTLE,
        S_DWELL,
        S_DUMP,
        S_WAIT_RES,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [4:0]      prn_q;
    logic            seek_en_q;
    logic [14:0]     seek_target_q;
    logic            corr_clear_q;
    logic            corr_dump_q;
    logic            busy_q;
    logic            done_q;
    logic            found_q;
    logic [14:0]     best_shift_q;
    logic [31:0]     best_power_q;
    logic [11:0]     bin_cnt_q;
    logic [11:0]     last_bin_q;
    logic            seek_first_q;
    logic            settle_cnt_q;
    logic [DCW-1:0]  dwell_cnt_q;

    // Next bin's code shift. The sum of two values below CODE_LEN fits in
    // 16 bits, so a single conditional subtract performs the modulo.
    logic [15:0]     tgt_sum_d;
    logic [14:0]     tgt_next_d;
    logic [11:0]     last_bin_d;
    logic            thresh_hit_d;

    always_comb begin
        tgt_sum_d  = {1'b0, seek_target_q} + STEP16;
        tgt_next_d = tgt_sum_d[14:0];
        if (tgt_sum_d >= CODE16) begin
            tgt_next_d = 15'(tgt_sum_d - CODE16);
        end
    end

    // A request for zero bins still searches one bin.
    assign last_bin_d = (num_bins == 12'd0) ? 12'd0 : (num_bins - 12'd1);

`ifdef CA_SEARCH_THRESH_EN
    assign thresh_hit_d = (corr_power >= threshold);
    assign found        = found_q;
`else
    assign thresh_hit_d = 1'b0;
    assign found        = 1'b0;
    logic unused_thresh;
    assign unused_thresh = found_q ^ (^threshold);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            prn_q         <= '0;
            seek_en_q     <= 1'b0;
            seek_target_q <= '0;
            corr_clear_q  <= 1'b0;
            corr_dump_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            best_shift_q  <= '0;
            best_power_q  <= '0;
            bin_cnt_q     <= '0;
            last_bin_q    <= '0;
            seek_first_q  <= 1'b0;
            settle_cnt_q  <= 1'b0;
            dwell_cnt_q   <= '0;
        end else if (abort && (state_q != S_IDLE)) begin
            // Cancel without a done pulse; results keep their partial values.
            state_q      <= S_IDLE;
            seek_en_q    <= 1'b0;
            corr_clear_q <= 1'b0;
            corr_dump_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            corr_clear_q <= 1'b0;
            corr_dump_q  <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        prn_q         <= prn_in;
                        seek_target_q <= start_shift;
                        best_shift_q  <= start_shift;
                        best_power_q  <= '0;
                        found_q       <= 1'b0;
                        bin_cnt_q     <= '0;
                        last_bin_q    <= last_bin_d;
                        seek_en_q     <= 1'b1;
                        seek_first_q  <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_SEEK;
                    end
                end
                S_SEEK: begin
                    // The upsampler has not seen seek_en yet on the first
                    // cycle, so its seeking flag is stale there.
                    if (seek_first_q) begin
                        seek_first_q <= 1'b0;
                    end else if (!seeking) begin
                        seek_en_q    <= 1'b0;
                        settle_cnt_q <= 1'b0;
                        state_q      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // Two cycles for the upsampler output pipeline to drain.
                    if (settle_cnt_q) begin
                        corr_clear_q <= 1'b1;
                        dwell_cnt_q  <= '0;
                        state_q      <= S_DWELL;
                    end else begin
                        settle_cnt_q <= 1'b1;
                    end
                end
                S_DWELL: begin
                    if (sample_valid) begin
                        if (dwell_cnt_q == DWELL_LAST) begin
                            corr_dump_q <= 1'b1;
                            state_q     <= S_DUMP;
                        end else begin
                            dwell_cnt_q <= dwell_cnt_q + 1'b1;
                        end
                    end
                end
                S_DUMP: begin
                    state_q <= S_WAIT_RES;
                end
                S_WAIT_RES: begin
                    if (corr_power_valid) begin
                        if (thresh_hit_d) begin
                            found_q      <= 1'b1;
                            best_power_q <= corr_power;
                            best_shift_q <= seek_target_q;
                            done_q       <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            // Strictly greater: the earliest of equal peaks wins.
                            if (corr_power > best_power_q) begin
                                best_power_q <= corr_power;
                                best_shift_q <= seek_target_q;
                            end
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (bin_cnt_q == last_bin_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        seek_target_q <= tgt_next_d;
                        bin_cnt_q     <= bin_cnt_q + 12'd1;
                        seek_en_q     <= 1'b1;
                        seek_first_q  <= 1'b1;
                        state_q       <= S_SEEK;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    seek_en_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign prn         = prn_q;
    assign seek_en     = seek_en_q;
    assign seek_target = seek_target_q;
    assign corr_clear  = corr_clear_q;
    assign corr_dump   = corr_dump_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign best_shift  = best_shift_q;
    assign best_power  = best_power_q;

endmodule

// File: tb/tb_ca_search_sequencer.sv
// Directed bench for ca_search_sequencer (STEP 8, DWELL 16, CODE_LEN 16800).
// Small responders model the upsampler seek flag and the correlator result;
// a negedge monitor logs seek targets, pulse counts and pulse spacing.
module tb_ca_search_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [4:0]  prn_in;
    logic [14:0] start_shift;
    logic [11:0] num_bins;
    logic [31:0] threshold;
    logic        sample_valid;
    logic        seeking;
    logic [31:0] corr_power;
    logic        corr_power_valid;
    logic [4:0]  prn;
    logic        seek_en;
    logic [14:0] seek_target;
    logic        corr_clear;
    logic        corr_dump;
    logic        busy;
    logic        done;
    logic        found;
    logic [14:0] best_shift;
    logic [31:0] best_power;

    ca_search_sequencer #(
        .CODE_LEN(16800),
        .STEP    (8),
        .DWELL   (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .prn_in          (prn_in),
        .start_shift     (start_shift),
        .num_bins        (num_bins),
        .threshold       (threshold),
        .sample_valid    (sample_valid),
        .seeking         (seeking),
        .corr_power      (corr_power),
        .corr_power_valid(corr_power_valid),
        .prn             (prn),
        .seek_en         (seek_en),
        .seek_target     (seek_target),
        .corr_clear      (corr_clear),
        .corr_dump       (corr_dump),
        .busy            (busy),
        .done            (done),
        .found           (found),
        .best_shift      (best_shift),
        .best_power      (best_power)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sample strobe on every other cycle, changed just after the edge.
    initial begin
        sample_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sample_valid = ~sample_valid;
        end
    end

    // Upsampler seek model: seeking drops on the third cycle of seek_en.
    initial begin
        int cnt;
        cnt = 0;
        seeking = 1'b0;
        forever begin
            @(negedge clk);
            if (seek_en) begin
                cnt++;
                seeking = (cnt < 3);
            end else begin
                cnt = 0;
                seeking = 1'b0;
            end
        end
    end

    // Correlator model: one result per dump, taken from pw_tab in order.
    logic [31:0] pw_tab [0:63];
    int          pw_idx = 0;
    bit          resp_en = 1'b1;
    bit          inj_valid = 1'b0;

    initial begin
        corr_power_valid = 1'b0;
        corr_power       = '0;
        forever begin
            @(posedge clk);
            #1;
            corr_power_valid = 1'b0;
            if (inj_valid) begin
                corr_power       = 32'd99;
                corr_power_valid = 1'b1;
            end else if (corr_dump && resp_en) begin
                @(posedge clk);
                #1;
                corr_power       = pw_tab[pw_idx];
                corr_power_valid = 1'b1;
                pw_idx++;
            end
        end
    end

    // Monitor: targets at each seek_en rise, pulse counts and spacing.
    logic [14:0] tgt_log [0:63];
    int  tgt_n = 0, done_cnt = 0, dump_cnt = 0, cyc = 0;
    int  fall_cyc = 0, val_cyc = 0, clr_gap = -1, res_gap = -1, seek_gap = -1;
    int  sv_cnt = 0, dwell_seen = -1;
    bit  sv_win = 1'b0;
    logic seek_en_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (seek_en === 1'b1 && seek_en_prev === 1'b0) begin
            tgt_log[tgt_n] = seek_target;
            tgt_n++;
            seek_gap = cyc - val_cyc;
        end
        if (seek_en === 1'b0 && seek_en_prev === 1'b1) fall_cyc = cyc;
        if (done === 1'b1) begin
            done_cnt++;
            res_gap = cyc - val_cyc;
        end
        if (corr_power_valid) val_cyc = cyc;
        if (corr_clear === 1'b1) begin
            clr_gap = cyc - fall_cyc;
            sv_win  = 1'b1;
            sv_cnt  = 0;
        end
        if (sv_win) begin
            if (corr_dump === 1'b1) begin
                sv_win     = 1'b0;
                dwell_seen = sv_cnt;
                dump_cnt++;
            end else if (sample_valid) begin
                sv_cnt++;
            end
        end
        seek_en_prev = seek_en;
    end

    function automatic logic pick(input int sel);
        case (sel)
            0:       return done;
            1:       return corr_clear;
            default: return corr_dump;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int max_cyc, input string tag);
        int   n;
        logic v;
        n = 0;
        v = pick(sel);
        while (v !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
            v = pick(sel);
        end
        check(tag, 32'(v), 32'd1);
    endtask

    task automatic set_pw(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
        pw_tab[pw_idx]     = a;
        pw_tab[pw_idx + 1] = b;
        pw_tab[pw_idx + 2] = c;
        pw_tab[pw_idx + 3] = d;
    endtask

    task automatic do_start(input logic [4:0] p, input logic [14:0] sh, input logic [11:0] nb);
        prn_in      = p;
        start_shift = sh;
        num_bins    = nb;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic check_all_zero(input string pre);
        check({pre, "_prn"},         32'(prn),         32'd0);
        check({pre, "_seek_en"},     32'(seek_en),     32'd0);
        check({pre, "_seek_target"}, 32'(seek_target), 32'd0);
        check({pre, "_corr_clear"},  32'(corr_clear),  32'd0);
        check({pre, "_corr_dump"},   32'(corr_dump),   32'd0);
        check({pre, "_busy"},        32'(busy),        32'd0);
        check({pre, "_done"},        32'(done),        32'd0);
        check({pre, "_found"},       32'(found),       32'd0);
        check({pre, "_best_shift"},  32'(best_shift),  32'd0);
        check({pre, "_best_power"},  best_power,       32'd0);
    endtask

    initial begin
        int base_t, base_d, base_dump;

        reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        prn_in      = '0;
        start_shift = '0;
        num_bins    = '0;
        threshold   = 32'd50;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Basic search: powers 5, 9, 9, 2 -> first 9 wins at shift 108
        base_t = tgt_n; base_d = done_cnt; base_dump = dump_cnt;
        set_pw(32'd5, 32'd9, 32'd9, 32'd2);
        do_start(5'd7, 15'd100, 12'd4);
        check("basic_busy_after_start", 32'(busy), 32'd1);
        check("basic_seek_en_after_start", 32'(seek_en), 32'd1);
        check("basic_prn", 32'(prn), 32'd7);
        check("basic_first_target", 32'(seek_target), 32'd100);
        wait_for(0, 2000, "basic_done_seen");
        $display("basic: done best_shift=%0d best_power=%0d", best_shift, best_power);
        check("basic_best_shift", 32'(best_shift), 32'd108);
        check("basic_best_power", best_power, 32'd9);
        check("basic_busy_in_done", 32'(busy), 32'd1);
        check("basic_found", 32'(found), 32'd0);
        @(negedge clk);
        check("basic_done_one_cycle", 32'(done), 32'd0);
        check("basic_idle_after_done", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("basic_done_count", 32'(done_cnt - base_d), 32'd1);
        check("basic_bin_count", 32'(tgt_n - base_t), 32'd4);
        check("basic_target0", 32'(tgt_log[base_t]), 32'd100);
        check("basic_target1", 32'(tgt_log[base_t + 1]), 32'd108);
        check("basic_target2", 32'(tgt_log[base_t + 2]), 32'd116);
        check("basic_target3", 32'(tgt_log[base_t + 3]), 32'd124);
        check("basic_dump_count", 32'(dump_cnt - base_dump), 32'd4);
        check("basic_dwell_samples", 32'(dwell_seen), 32'd16);
        check("basic_seek_to_clear_gap", 32'(clr_gap), 32'd2);
        check("basic_result_to_seek_gap", 32'(seek_gap), 32'd2);
        check("basic_result_to_done_gap", 32'(res_gap), 32'd2);
        check("basic_best_held", best_power, 32'd9);

        // Abort mid-DWELL: no done, partial results kept
        base_d = done_cnt; base_dump = dump_cnt;
        set_pw(32'd40, 32'd40, 32'd40, 32'd40);
        do_start(5'd3, 15'd300, 12'd5);
        wait_for(1, 200, "abort_reach_dwell");
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        $display("abort: busy=%0d seek_en=%0d", busy, seek_en);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_seek_en", 32'(seek_en), 32'd0);
        check("abort_best_shift_kept", 32'(best_shift), 32'd300);
        check("abort_best_power_kept", best_power, 32'd0);
        repeat (60) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - base_d), 32'd0);
        check("abort_no_dump", 32'(dump_cnt - base_dump), 32'd0);

        // A fresh start after abort runs normally
        base_d = done_cnt;
        set_pw(32'd7, 32'd0, 32'd0, 32'd0);
        do_start(5'd4, 15'd200, 12'd1);
        check("post_abort_busy", 32'(busy), 32'd1);
        wait_for(0, 2000, "post_abort_done_seen");
        $display("post_abort: best_shift=%0d best_power=%0d", best_shift, best_power);
        check("post_abort_best_shift", 32'(best_shift), 32'd200);
        check("post_abort_best_power", best_power, 32'd7);
        check("post_abort_prn", 32'(prn), 32'd4);
        repeat (3) @(negedge clk);
        check("post_abort_done_count", 32'(done_cnt - base_d), 32'd1);

        // Wrap-around of the code shift; a stray start mid-search is ignored
        base_t = tgt_n;
        set_pw(32'd1, 32'd1, 32'd1, 32'd0);
        do_start(5'd1, 15'd16792, 12'd3);
        wait_for(1, 200, "wrap_reach_dwell");
        start_shift = 15'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for(0, 2000, "wrap_done_seen");
        $display("wrap: best_shift=%0d best_power=%0d", best_shift, best_power);
        check("wrap_best_shift", 32'(best_shift), 32'd16792);
        check("wrap_best_power", best_power, 32'd1);
        repeat (3) @(negedge clk);
        check("wrap_bin_count", 32'(tgt_n - base_t), 32'd3);
        check("wrap_target0", 32'(tgt_log[base_t]), 32'd16792);
        check("wrap_target1", 32'(tgt_log[base_t + 1]), 32'd0);
        check("wrap_target2", 32'(tgt_log[base_t + 2]), 32'd8);

        // Reset during WAIT_RES; a late result is ignored
        base_d = done_cnt;
        resp_en = 1'b0;
        do_start(5'd2, 15'd500, 12'd2);
        wait_for(2, 400, "midrst_reach_dump");
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        $display("midrst: busy=%0d seek_target=%0d", busy, seek_target);
        check_all_zero("midrst");
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_late_result_ignored", best_power, 32'd0);
        check("midrst_still_idle", 32'(busy), 32'd0);
        check("midrst_no_done", 32'(done_cnt - base_d), 32'd0);
        resp_en = 1'b1;

        // Threshold 50 with powers 10, 60, ...
        base_t = tgt_n; base_d = done_cnt;
        threshold = 32'd50;
`ifdef CA_SEARCH_THRESH_EN
        set_pw(32'd10, 32'd60, 32'd70, 32'd80);
        do_start(5'd9, 15'd100, 12'd4);
        wait_for(0, 2000, "thresh_done_seen");
        $display("thresh: found=%0d best_shift=%0d best_power=%0d", found, best_shift, best_power);
        check("thresh_found", 32'(found), 32'd1);
        check("thresh_best_shift", 32'(best_shift), 32'd108);
        check("thresh_best_power", best_power, 32'd60);
        repeat (3) @(negedge clk);
        check("thresh_bin_count", 32'(tgt_n - base_t), 32'd2);
`else
        set_pw(32'd10, 32'd60, 32'd5, 32'd0);
        do_start(5'd9, 15'd100, 12'd3);
        wait_for(0, 2000, "thresh_done_seen");
        $display("thresh_off: found=%0d best_shift=%0d best_power=%0d", found, best_shift, best_power);
        check("thresh_off_found", 32'(found), 32'd0);
        check("thresh_off_best_shift", 32'(best_shift), 32'd108);
        check("thresh_off_best_power", best_power, 32'd60);
        repeat (3) @(negedge clk);
        check("thresh_off_bin_count", 32'(tgt_n - base_t), 32'd3);
`endif
        check("thresh_done_count", 32'(done_cnt - base_d), 32'd1);

        // num_bins = 0 searches exactly one bin
        base_t = tgt_n; base_d = done_cnt;
        set_pw(32'd3, 32'd0, 32'd0, 32'd0);
        do_start(5'd5, 15'd42, 12'd0);
        check("degen_found_cleared", 32'(found), 32'd0);
        wait_for(0, 2000, "degen_done_seen");
        $display("degen: best_shift=%0d best_power=%0d", best_shift, best_power);
        check("degen_best_shift", 32'(best_shift), 32'd42);
        check("degen_best_power", best_power, 32'd3);
        repeat (3) @(negedge clk);
        check("degen_bin_count", 32'(tgt_n - base_t), 32'd1);
        check("degen_done_count", 32'(done_cnt - base_d), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ca_search_sequencer.md
# ca_search_sequencer

Sequences a serial code-phase search for one PRN by driving the seek interface of the C/A upsampler. For each bin it sets a code-shift target and waits for the seek to finish. It then clears the correlator, dwells for a fixed number of input samples, dumps the correlator and records the peak correlation power. It sits between the acquisition control registers and the upsampler/correlator pair.

## Interface
Parameters:
- `CODE_LEN`, 16800: code-shift modulus; the upsampler code shift runs 0..16799.
- `STEP`, 8: code-shift increment between bins (about half a chip). Must satisfy 0 < STEP < CODE_LEN.
- `DWELL`, 16800: number of `sample_valid` pulses per bin (1 ms).

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle search request; sampled in IDLE only.
- `abort` in 1: cancels a running search.
- `prn_in` in 5: PRN to search; latched on `start`.
- `start_shift` in 15: first bin's code shift, must be < CODE_LEN; latched on `start`.
- `num_bins` in 12: number of bins; 0 is treated as 1; latched on `start`.
- `threshold` in 32: early-stop power level; used only with `CA_SEARCH_THRESH_EN`.
- `sample_valid` in 1: upsampler `enable` strobe (one per input sample).
- `seeking` in 1: upsampler seek-in-progress flag.
- `corr_power` in 32: unsigned correlation power.
- `corr_power_valid` in 1: `corr_power` is valid this cycle.
- `prn` out 5: PRN to upsampler.
- `seek_en` out 1: upsampler seek enable.
- `seek_target` out 15: upsampler seek target.
- `corr_clear` out 1: one-cycle correlator clear.
- `corr_dump` out 1: one-cycle correlator dump request.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `found` out 1: threshold crossed. Constant 0 when the threshold feature is compiled out.
- `best_shift` out 15: code shift of the peak bin.
- `best_power` out 32: power of the peak bin.

## Operation
- States: IDLE, SEEK, SETTLE, DWELL, DUMP, WAIT_RES, NEXT, DONE.
- IDLE, on `start`:
  - latch inputs; set `seek_target` = `start_shift`, bin counter = 0, `best_power` = 0, `best_shift` = `start_shift`, `found` = 0;
  - go to SEEK.
- SEEK:
  - `seek_en` = 1.
  - The first cycle in SEEK ignores `seeking`, so the upsampler sees `seek_en`.
  - From the second cycle on, `seeking` = 0 clears `seek_en` and moves to SETTLE.
- SETTLE: hold 2 cycles so the delayed upsampler pipeline drains, then pulse `corr_clear` and go to DWELL.
- DWELL:
  - count `sample_valid` pulses;
  - on the DWELL-th pulse, go to DUMP.
- DUMP: pulse `corr_dump` for 1 cycle, go to WAIT_RES.
- WAIT_RES:
  - on `corr_power_valid`, compare `corr_power` with `best_power`;
  - if `corr_power` > `best_power` (strictly greater, so the first maximum wins), update `best_power` and `best_shift` = `seek_target`;
  - go to NEXT.
- NEXT:
  - if the bin counter equals num_bins−1, go to DONE;
  - otherwise add STEP to `seek_target`, subtracting CODE_LEN if the sum is ≥ CODE_LEN (16-bit intermediate), increment the bin counter, and go to SEEK.
- DONE: pulse `done` for 1 cycle, return to IDLE.
- Outside their states:
  - `start` is ignored outside IDLE;
  - `corr_power_valid` is ignored outside WAIT_RES;
  - `sample_valid` is ignored outside DWELL.
- `abort`, in any non-IDLE state:
  - next state is IDLE, `seek_en` = 0;
  - no `done` pulse;
  - result registers keep their partial values.
- `abort` and `start` together in IDLE: `start` wins (abort has no effect in IDLE).

## Timing
- Reset (`reset_n` = 0 at a clock edge):
  - state IDLE;
  - all outputs 0, including `prn`, `seek_target`, `best_shift` and `best_power`.
- Reset mid-search has the same effect; no pulses are emitted.
- `start` sampled at edge N: `busy` = 1 and `seek_en` = 1 from edge N+1.
- `seeking` low with SEEK past its first cycle at edge M:
  - `seek_en` = 0 from M+1;
  - `corr_clear` high for the cycle M+3..M+4.
- DWELL-th `sample_valid` at edge D: `corr_dump` high for the cycle D+1..D+2.
- `corr_power_valid` at edge R:
  - `best_*` updated at R+1;
  - next `seek_en` rises at R+2, or `done` is high R+2..R+3.
- `done` and the final `best_*` values are valid together, and `best_*` holds until the next `start`.
- Wrap-around: a target of 16796 with STEP 8 gives 4.

## Configuration
- `CA_SEARCH_THRESH_EN` defined:
  - in WAIT_RES, `corr_power` ≥ `threshold` sets `found` = 1, updates `best_*` unconditionally, and goes directly to DONE, skipping the remaining bins;
  - `found` is cleared on the next `start`.
- Undefined: `threshold` is ignored, `found` is tied to 0, and the search always visits all bins.

## Test plan
- Basic search:
  - stimulus: `start`, `start_shift` = 100, `num_bins` = 4, DWELL = 16, `seeking` low 3 cycles after each `seek_en` rise, powers 5, 9, 9, 2;
  - required: targets 100, 108, 116, 124; `best_shift` = 108, `best_power` = 9; exactly one `done`.
- Wrap:
  - stimulus: `start_shift` = 16792, `num_bins` = 3;
  - required: targets 16792, 0, 8.
- Abort:
  - stimulus: assert `abort` mid-DWELL;
  - required: IDLE next cycle, `seek_en` = 0, no `done`; a subsequent `start` runs normally.
- Reset:
  - stimulus: `reset_n` low during WAIT_RES;
  - required: all outputs 0 after the edge; a late `corr_power_valid` is ignored.
- Degenerate bins:
  - stimulus: `num_bins` = 0;
  - required: exactly one bin is searched, then `done`.
- Threshold (with `CA_SEARCH_THRESH_EN`):
  - stimulus: `threshold` = 50, powers 10, 60, …;
  - required: `found` = 1, `best_shift` = second target, `done` after 2 bins.
